// File: rtl/cascade_counter_pkg.sv
// cascade_counter_pkg: mode constants and digit-slice helper shared by the
// cascaded counter and the display logic that reads its packed COUNT bus.
`default_nettype none

`ifndef CASCADE_COUNTER_DIGIT_SLICE
`define CASCADE_COUNTER_DIGIT_SLICE
`define DIGIT_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

package cascade_counter_pkg;

   localparam int MODE_WRAP = 1;
   localparam int MODE_SAT  = 0;

endpackage

`default_nettype wire

// File: rtl/cascade_counter_digit.sv
// counter_digit: one modulo-(DIGIT_MAX+1) digit with clear, clamped load
// and a single up/down step driven by the carry chain in the parent.
`default_nettype none

module counter_digit #(
   parameter int DIGIT_WIDTH = 4,
   parameter int DIGIT_MAX   = 9
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   clear_i,
   input  logic                   load_i,
   input  logic [DIGIT_WIDTH-1:0] load_val_i,
   input  logic                   step_i,
   input  logic                   down_i,
   output logic [DIGIT_WIDTH-1:0] digit_o,
   output logic                   at_max_o,
   output logic                   at_zero_o
);

   localparam logic [DIGIT_WIDTH-1:0] MAX_V = DIGIT_WIDTH'(DIGIT_MAX);
   localparam logic [DIGIT_WIDTH-1:0] ONE_V = DIGIT_WIDTH'(1);

   logic [DIGIT_WIDTH-1:0] digit_q;
   logic [DIGIT_WIDTH-1:0] digit_d;

   assign digit_o   = digit_q;
   assign at_max_o  = (digit_q == MAX_V);
   assign at_zero_o = (digit_q == '0);

   always_comb begin
      digit_d = digit_q;
      if (clear_i) begin
         digit_d = '0;
      end else if (load_i) begin
         digit_d = (load_val_i > MAX_V) ? MAX_V : load_val_i;
      end else if (step_i) begin
         if (down_i) begin
            digit_d = at_zero_o ? MAX_V : (digit_q - ONE_V);
         end else begin
            digit_d = at_max_o ? '0 : (digit_q + ONE_V);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         digit_q <= '0;
      end else begin
         digit_q <= digit_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/cascade_counter.sv
// cascade_counter: NUM_DIGITS chained digits counting up/down with clear,
// clamped load, wrap-or-saturate limits and a registered limit pulse.
`default_nettype none

module cascade_counter
   import cascade_counter_pkg::*;
#(
   parameter int DIGIT_WIDTH = 4,
   parameter int DIGIT_MAX   = 9,
   parameter int NUM_DIGITS  = 4,
   parameter int WRAP        = 1
) (
   input  logic                              CLK,
   input  logic                              RESET_N,
   input  logic                              CLEAR,
   input  logic                              LOAD,
   input  logic [NUM_DIGITS*DIGIT_WIDTH-1:0] LOAD_VALUE,
   input  logic                              ENABLE_IN,
   input  logic                              DOWN,
   output logic [NUM_DIGITS*DIGIT_WIDTH-1:0] COUNT,
   output logic                              TRIG_OUT,
   output logic                              AT_ZERO
);

   logic [NUM_DIGITS-1:0] w_at_max;
   logic [NUM_DIGITS-1:0] w_at_zero;
   logic [NUM_DIGITS-1:0] w_step;
   logic                  w_req;
   logic                  w_limit;
   logic                  w_hold;
   logic                  w_chain;
   logic                  trig_d;
   logic                  trig_q;

   assign w_req   = ENABLE_IN & ~CLEAR & ~LOAD;
   assign w_limit = DOWN ? (&w_at_zero) : (&w_at_max);
   // In saturate mode a step at the limit is swallowed entirely so every digit holds.
   assign w_hold  = w_limit & (WRAP != MODE_WRAP);
   assign trig_d  = w_req & w_limit;

   always_comb begin
      w_chain = w_req & ~w_hold;
      w_step  = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_step[i] = w_chain;
         w_chain   = w_chain & (DOWN ? w_at_zero[i] : w_at_max[i]);
      end
   end

   generate
      for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
         counter_digit #(
            .DIGIT_WIDTH (DIGIT_WIDTH),
            .DIGIT_MAX   (DIGIT_MAX)
         ) u_digit (
            .clk_i      (CLK),
            .rst_ni     (RESET_N),
            .clear_i    (CLEAR),
            .load_i     (LOAD),
            .load_val_i (LOAD_VALUE[g*DIGIT_WIDTH +: DIGIT_WIDTH]),
            .step_i     (w_step[g]),
            .down_i     (DOWN),
            .digit_o    (COUNT[g*DIGIT_WIDTH +: DIGIT_WIDTH]),
            .at_max_o   (w_at_max[g]),
            .at_zero_o  (w_at_zero[g])
         );
      end
   endgenerate

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         trig_q <= 1'b0;
      end else begin
         trig_q <= trig_d;
      end
   end

   assign TRIG_OUT = trig_q;
   assign AT_ZERO  = &w_at_zero;

endmodule

`default_nettype wire

// File: tb/tb_cascade_counter.sv
// tb_cascade_counter: directed vectors with a scoreboard queue checked by a
// separate monitor, over wrap, saturate and single hex-digit configurations.
`default_nettype none

module tb_cascade_counter;
   import cascade_counter_pkg::*;

   logic       CLK = 1'b0;
   logic       RESET_N;
   logic       CLEAR;
   logic       LOAD;
   logic       ENABLE_IN;
   logic       DOWN;
   logic [7:0] LOAD_VALUE;

   logic [7:0] cnt0, cnt1;
   logic [3:0] cnt2;
   logic       trig0, trig1, trig2;
   logic       z0, z1, z2;

   typedef struct {
      int         id;
      logic [7:0] cnt;
      logic       trig;
      string      name;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   always #5 CLK = ~CLK;

   cascade_counter #(.DIGIT_WIDTH(4), .DIGIT_MAX(9), .NUM_DIGITS(2), .WRAP(MODE_WRAP)) u_wrap (
      .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR), .LOAD(LOAD), .LOAD_VALUE(LOAD_VALUE),
      .ENABLE_IN(ENABLE_IN), .DOWN(DOWN), .COUNT(cnt0), .TRIG_OUT(trig0), .AT_ZERO(z0));

   cascade_counter #(.DIGIT_WIDTH(4), .DIGIT_MAX(9), .NUM_DIGITS(2), .WRAP(MODE_SAT)) u_sat (
      .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR), .LOAD(LOAD), .LOAD_VALUE(LOAD_VALUE),
      .ENABLE_IN(ENABLE_IN), .DOWN(DOWN), .COUNT(cnt1), .TRIG_OUT(trig1), .AT_ZERO(z1));

   cascade_counter #(.DIGIT_WIDTH(4), .DIGIT_MAX(15), .NUM_DIGITS(1), .WRAP(MODE_WRAP)) u_hex (
      .CLK(CLK), .RESET_N(RESET_N), .CLEAR(CLEAR), .LOAD(LOAD), .LOAD_VALUE(LOAD_VALUE[3:0]),
      .ENABLE_IN(ENABLE_IN), .DOWN(DOWN), .COUNT(cnt2), .TRIG_OUT(trig2), .AT_ZERO(z2));

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: each cycle with a pending expectation compares the selected DUT.
   always @(posedge CLK) begin
      #1;
      if (sb.size() != 0) begin
         mon_e = sb.pop_front();
         case (mon_e.id)
            0: begin
               chk({mon_e.name, " count"}, cnt0, mon_e.cnt);
               chk({mon_e.name, " trig"}, {7'd0, trig0}, {7'd0, mon_e.trig});
               chk({mon_e.name, " at_zero"}, {7'd0, z0}, {7'd0, mon_e.cnt == 8'h00});
            end
            1: begin
               chk({mon_e.name, " count"}, cnt1, mon_e.cnt);
               chk({mon_e.name, " trig"}, {7'd0, trig1}, {7'd0, mon_e.trig});
               chk({mon_e.name, " at_zero"}, {7'd0, z1}, {7'd0, mon_e.cnt == 8'h00});
            end
            default: begin
               chk({mon_e.name, " count"}, {4'd0, cnt2}, mon_e.cnt);
               chk({mon_e.name, " trig"}, {7'd0, trig2}, {7'd0, mon_e.trig});
               chk({mon_e.name, " at_zero"}, {7'd0, z2}, {7'd0, mon_e.cnt == 8'h00});
            end
         endcase
      end
   end

   task automatic cyc(input int id, input logic clr, input logic ld, input logic [7:0] lv,
                      input logic en, input logic dn, input logic [7:0] ecnt,
                      input logic etrig, input string nm);
      exp_t e;
      @(negedge CLK);
      CLEAR      = clr;
      LOAD       = ld;
      LOAD_VALUE = lv;
      ENABLE_IN  = en;
      DOWN       = dn;
      e.id   = id;
      e.cnt  = ecnt;
      e.trig = etrig;
      e.name = nm;
      sb.push_back(e);
   endtask

   task automatic idle();
      @(negedge CLK);
      CLEAR      = 1'b0;
      LOAD       = 1'b0;
      LOAD_VALUE = 8'h00;
      ENABLE_IN  = 1'b0;
      DOWN       = 1'b0;
   endtask

   function automatic logic [7:0] bcd(input int v);
      return {4'((v % 100) / 10), 4'(v % 10)};
   endfunction

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      RESET_N    = 1'b0;
      CLEAR      = 1'b0;
      LOAD       = 1'b0;
      LOAD_VALUE = 8'h00;
      ENABLE_IN  = 1'b0;
      DOWN       = 1'b0;
      #2;
      chk("reset count", cnt0, 8'h00);
      chk("reset trig", {7'd0, trig0}, 8'h00);
      chk("reset at_zero", {7'd0, z0}, 8'h01);
      chk("reset hex count", {4'd0, cnt2}, 8'h00);
      @(negedge CLK);
      RESET_N = 1'b1;

      // Asynchronous reset between edges while holding a non-zero count
      cyc(0, 0, 1, 8'h37, 0, 0, 8'h37, 0, "load37");
      idle();
      @(posedge CLK);
      #3;
      RESET_N = 1'b0;
      #1;
      chk("async rst count", cnt0, 8'h00);
      chk("async rst trig", {7'd0, trig0}, 8'h00);
      chk("async rst at_zero", {7'd0, z0}, 8'h01);
      @(negedge CLK);
      RESET_N = 1'b1;

      // Up through every value to rollover
      cyc(0, 1, 0, 8'h00, 0, 0, 8'h00, 0, "clr");
      for (int k = 1; k <= 100; k++)
         cyc(0, 0, 0, 8'h00, 1, 0, bcd(k), k == 100, $sformatf("up%0d", k));

      // Borrow and down wrap
      cyc(0, 0, 1, 8'h10, 0, 0, 8'h10, 0, "load10");
      cyc(0, 0, 0, 8'h00, 1, 1, 8'h09, 0, "borrow");
      cyc(0, 1, 0, 8'h00, 0, 0, 8'h00, 0, "clr2");
      cyc(0, 0, 0, 8'h00, 1, 1, 8'h99, 1, "downwrap");
      cyc(0, 0, 0, 8'h00, 1, 1, 8'h98, 0, "down98");

      // Load clamp and priority
      cyc(0, 0, 1, 8'h3A, 0, 0, 8'h39, 0, "clamp");
      cyc(0, 0, 1, 8'h25, 1, 0, 8'h25, 0, "load_en");
      cyc(0, 0, 1, 8'h99, 0, 0, 8'h99, 0, "load99");
      cyc(0, 0, 1, 8'h99, 1, 0, 8'h99, 0, "load_at_lim");
      cyc(0, 1, 1, 8'h55, 0, 0, 8'h00, 0, "clr_load");
      cyc(0, 1, 0, 8'h00, 1, 1, 8'h00, 0, "clr_en");
      cyc(0, 0, 0, 8'h00, 1, 0, 8'h01, 0, "up01");

      // Saturate configuration
      cyc(1, 0, 1, 8'h99, 0, 0, 8'h99, 0, "sat_load");
      for (int k = 1; k <= 3; k++)
         cyc(1, 0, 0, 8'h00, 1, 0, 8'h99, 1, $sformatf("sat_up%0d", k));
      cyc(1, 0, 0, 8'h00, 0, 0, 8'h99, 0, "sat_idle");
      cyc(1, 0, 0, 8'h00, 1, 1, 8'h98, 0, "sat_dn");
      cyc(1, 1, 0, 8'h00, 0, 0, 8'h00, 0, "sat_clr");
      cyc(1, 0, 0, 8'h00, 1, 1, 8'h00, 1, "sat_dn0");
      cyc(1, 0, 0, 8'h00, 1, 0, 8'h01, 0, "sat_up01");

      // Single hex digit, both directions
      cyc(2, 1, 0, 8'h00, 0, 0, 8'h00, 0, "hex_clr");
      for (int k = 1; k <= 16; k++)
         cyc(2, 0, 0, 8'h00, 1, 0, 8'(k % 16), k == 16, $sformatf("hex_up%0d", k));
      for (int k = 1; k <= 16; k++)
         cyc(2, 0, 0, 8'h00, 1, 1, 8'((16 - k) % 16), k == 1, $sformatf("hex_dn%0d", k));

      idle();
      idle();
      idle();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cascade_counter.md
# cascade_counter

Parametrised multi-digit cascaded counter: the successor to the single-digit generic counter used for score, lives and timing dividers. NUM_DIGITS modulo-(DIGIT_MAX+1) digits are chained with carry/borrow, and the block counts up or down with synchronous clear, parallel load, and wrap or saturate mode. A registered TRIG_OUT pulse marks the whole-counter rollover or limit hit. It sits between game-event logic and the score/display path.

## Interface
Parameters:
- DIGIT_WIDTH, 4: bits per digit.
- DIGIT_MAX, 9: largest digit value; must be < 2^DIGIT_WIDTH.
- NUM_DIGITS, 4: number of cascaded digits, ≥1; digit 0 is least significant.
- WRAP, 1: 1 = wrap at limits; 0 = saturate at limits.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET_N  in  1  asynchronous, active-low reset.
- CLEAR  in  1  synchronous clear to all-zero.
- LOAD  in  1  synchronous parallel load from LOAD_VALUE.
- LOAD_VALUE  in  NUM_DIGITS*DIGIT_WIDTH  packed load digits; digit i at [i*DIGIT_WIDTH +: DIGIT_WIDTH].
- ENABLE_IN  in  1  step request for this cycle.
- DOWN  in  1  step direction: 0 = increment, 1 = decrement; sampled only with ENABLE_IN.
- COUNT  out  NUM_DIGITS*DIGIT_WIDTH  packed current digits, registered.
- TRIG_OUT  out  1  registered one-cycle rollover/limit pulse.
- AT_ZERO  out  1  combinational: all digits 0.

## Operation
- Priority per cycle: CLEAR > LOAD > ENABLE_IN. CLEAR or LOAD suppress the step and force TRIG_OUT to 0 that cycle.
- LOAD clamps each digit independently: a digit value > DIGIT_MAX loads as DIGIT_MAX.
- Up step: digit 0 increments. Digit i steps when all digits below it are at DIGIT_MAX. A digit at DIGIT_MAX that steps becomes 0.
- Down step: digit 0 decrements. Digit i steps when all digits below it are 0. A digit at 0 that steps becomes DIGIT_MAX.
- Whole-counter limit: up from all-DIGIT_MAX, or down from all-zero.
  - WRAP=1: the counter wraps (to all-zero or all-DIGIT_MAX) and TRIG_OUT pulses.
  - WRAP=0: COUNT holds and TRIG_OUT pulses. The pulse repeats on every enabled step attempted while at the limit.
- TRIG_OUT is 0 on any cycle that is not an enabled step at the limit.
- Digits never hold values > DIGIT_MAX; all arithmetic is within DIGIT_WIDTH with no overflow.

## Timing
- Reset (RESET_N low, async, any time including mid-step): COUNT = 0, TRIG_OUT = 0, AT_ZERO = 1, effective immediately and held until release.
- Latency: 1 cycle. COUNT reflects a step, load, or clear on the first posedge after the request.
- TRIG_OUT rises on the same edge that COUNT shows the wrapped or held value, and lasts exactly 1 cycle per limit event.
- The carry chain is combinational within the cycle; there is no ripple delay between digits.
- ENABLE_IN held high for consecutive cycles gives one step per cycle.

## Structure
- Shared package/include holds the mode constants MODE_WRAP = 1 and MODE_SAT = 0, plus the digit-slice helper macro used by display logic.
- Sub-module counter_digit handles one digit: inputs step, down, load, load value, clear; outputs digit value, at_max, at_zero. It is instantiated NUM_DIGITS times in a generate loop.
- The top level owns the carry-enable chain, the limit detect, and the TRIG_OUT register.

## Test plan
All scenarios use NUM_DIGITS=2, DIGIT_MAX=9, DIGIT_WIDTH=4 unless stated.
- Reset mid-count: COUNT=0x37, drop RESET_N between edges -> COUNT=0x00, TRIG_OUT=0, AT_ZERO=1 immediately, before the next edge.
- Up rollover: from 0, ENABLE_IN high for 100 cycles -> COUNT=0x99 after 99 edges, 0x00 after edge 100, TRIG_OUT high only in that cycle. Carry checks: 0x09->0x10 and 0x19->0x20.
- Down with borrow: load 0x10, DOWN=1 step -> 0x09. From 0x00 one down step -> 0x99 with a TRIG_OUT pulse.
- Saturate (WRAP=0): at 0x99, 3 up steps -> COUNT stays 0x99, TRIG_OUT pulses 3 consecutive cycles. At 0x00, a down step -> stays 0x00, TRIG_OUT pulses.
- Load clamp and priority:
  - LOAD_VALUE=0x3A -> 0x39.
  - LOAD=1 with ENABLE_IN=1 on the same cycle -> loaded value, no step, no TRIG_OUT.
  - CLEAR=1 with LOAD=1 -> 0x00.
- Parameter sweep: NUM_DIGITS=1, DIGIT_MAX=15, WRAP=1 -> 16 up steps return to 0 with one TRIG_OUT pulse; 15->0 down path symmetric.
